// File: rtl/alu_mux_pkg.sv
// Shared CPU constants: datapath width and forwarding-select encoding.
package alu_mux_pkg;

    localparam int CPU_DATA_W = 19;

    localparam logic [1:0] FWD_EX   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_HOLD = 2'b11;

endpackage

// File: rtl/mux3_comb.sv
// Purely combinational 3:1 forwarding selector.
// The no-select flag marks the hold code and also any unknown select value.
module mux3_comb
    import alu_mux_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] c_data,
    output logic [DATA_W-1:0] y_data,
    output logic              no_sel
);

    always_comb begin
        y_data = '0;
        no_sel = 1'b1;
        // An X or Z select matches no item, so it lands in default and becomes a hold.
        case (sel)
            FWD_EX: begin
                y_data = a_data;
                no_sel = 1'b0;
            end
            FWD_MEM: begin
                y_data = b_data;
                no_sel = 1'b0;
            end
            FWD_WB: begin
                y_data = c_data;
                no_sel = 1'b0;
            end
            FWD_HOLD: no_sel = 1'b1;
            default:  no_sel = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mux.sv
// Registered ALU operand forwarding mux: picks EX, MEM or WB data, or holds.
module alu_mux
    import alu_mux_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] EX_data,
    input  logic [DATA_W-1:0] MEM_data,
    input  logic [DATA_W-1:0] WB_data,
    output logic [DATA_W-1:0] in
);

    logic [DATA_W-1:0] mux_data;
    logic              hold;
    logic [DATA_W-1:0] in_d;
    logic [DATA_W-1:0] in_q;

    mux3_comb #(
        .DATA_W (DATA_W)
    ) u_mux3 (
        .sel    (sel),
        .a_data (EX_data),
        .b_data (MEM_data),
        .c_data (WB_data),
        .y_data (mux_data),
        .no_sel (hold)
    );

    assign in_d = hold ? in_q : mux_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= '0;
        end else begin
            in_q <= in_d;
        end
    end

    assign in = in_q;

endmodule

// File: tb/tb_alu_mux.sv
// Bench for alu_mux: table-driven vectors through a scoreboard queue, plus reset/latency sequences.
module tb_alu_mux;

    localparam int W = 19;

    logic         clk;
    logic         rst;
    logic [1:0]   sel;
    logic [W-1:0] ex_d, mem_d, wb_d;
    logic [W-1:0] dut_in;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] ex;
        logic [W-1:0] mem;
        logic [W-1:0] wb;
        logic [W-1:0] exp_in;
    } vec_t;

    vec_t         vecs[16];
    logic [W-1:0] sb_q[$];

    alu_mux #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .EX_data  (ex_d),
        .MEM_data (mem_d),
        .WB_data  (wb_d),
        .in       (dut_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a vector after a falling edge, queue its expected result, compare one rising edge later.
    task automatic apply(input string name, input logic [1:0] s, input logic [W-1:0] e,
                         input logic [W-1:0] m, input logic [W-1:0] w, input logic [W-1:0] exp);
        logic [W-1:0] want;
        @(negedge clk);
        sel = s; ex_d = e; mem_d = m; wb_d = w;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %05h", name, dut_in);
        end else begin
            want = sb_q.pop_front();
            check(name, dut_in, want);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        sel = 2'b00;
        ex_d = 19'h1A5A5; mem_d = 19'h15A5A; wb_d = 19'h7FFFF;

        vecs[0]  = '{2'b00, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h1A5A5};
        vecs[1]  = '{2'b01, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h15A5A};
        vecs[2]  = '{2'b10, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h7FFFF};
        vecs[3]  = '{2'b01, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h15A5A};
        vecs[4]  = '{2'b11, 19'h00001, 19'h00001, 19'h00001, 19'h15A5A};
        vecs[5]  = '{2'b11, 19'h00001, 19'h00001, 19'h00001, 19'h15A5A};
        vecs[6]  = '{2'b11, 19'h00001, 19'h00001, 19'h00001, 19'h15A5A};
        vecs[7]  = '{2'b00, 19'h00123, 19'h3FFFF, 19'h2AAAA, 19'h00123};
        vecs[8]  = '{2'b00, 19'h00456, 19'h11111, 19'h22222, 19'h00456};
        vecs[9]  = '{2'b00, 19'h7FFFF, 19'h00000, 19'h00000, 19'h7FFFF};
        vecs[10] = '{2'b00, 19'h00000, 19'h7FFFF, 19'h7FFFF, 19'h00000};
        vecs[11] = '{2'b01, 19'h7FFFF, 19'h00000, 19'h7FFFF, 19'h00000};
        vecs[12] = '{2'b01, 19'h00000, 19'h7FFFF, 19'h00000, 19'h7FFFF};
        vecs[13] = '{2'b10, 19'h7FFFF, 19'h7FFFF, 19'h00000, 19'h00000};
        vecs[14] = '{2'b10, 19'h00000, 19'h00000, 19'h7FFFF, 19'h7FFFF};
        vecs[15] = '{2'b11, 19'h00000, 19'h00000, 19'h00000, 19'h7FFFF};

        // Async reset before any rising edge
        #1 rst = 1'b1;
        #1 check("reset_async", dut_in, 19'h00000);
        repeat (3) @(posedge clk);
        #1 check("reset_held", dut_in, 19'h00000);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            apply($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ex, vecs[i].mem,
                  vecs[i].wb, vecs[i].exp_in);

        // Async reset pulse between edges while holding 7FFFF
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("reset_mid_run", dut_in, 19'h00000);
        #1 rst = 1'b0;
        apply("post_reset_mem", 2'b01, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h15A5A);

        // Mid-cycle change on EX_data only shows at the next edge
        apply("latency_a", 2'b00, 19'h0ABCD, 19'h15A5A, 19'h7FFFF, 19'h0ABCD);
        #2 ex_d = 19'h12345;
        #1 check("no_glitch", dut_in, 19'h0ABCD);
        @(posedge clk);
        #1 check("latency_b", dut_in, 19'h12345);

        // Reset during a hold run; later holds keep 0
        apply("hold_pre", 2'b11, 19'h00001, 19'h00001, 19'h00001, 19'h12345);
        #2 rst = 1'b1;
        #1 check("reset_in_hold", dut_in, 19'h00000);
        #1 rst = 1'b0;
        apply("hold_after_reset0", 2'b11, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h00000);
        apply("hold_after_reset1", 2'b11, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h00000);
        apply("wb_after_hold", 2'b10, 19'h1A5A5, 19'h15A5A, 19'h7FFFF, 19'h7FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mux.md
# alu_mux

Operand-forwarding selector for the ALU input of the 19-bit pipelined CPU. It picks one of three pipeline-stage results (EX, MEM, WB) according to a 2-bit select from the forwarding unit. It presents the chosen word as a registered ALU operand. One instance sits in front of each ALU operand port.

## Interface
Parameters:
- DATA_W, default 19: width of every data port.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- sel, input, 2: forwarding select from the hazard/forwarding unit.
- EX_data, input, DATA_W: result forwarded from the EX stage.
- MEM_data, input, DATA_W: result forwarded from the MEM stage.
- WB_data, input, DATA_W: result forwarded from the WB stage.
- in, output, DATA_W: registered ALU operand.

## Operation
- The select encoding is fixed:
  - 2'b00 -> EX_data
  - 2'b01 -> MEM_data
  - 2'b10 -> WB_data
  - 2'b11 -> hold; `in` keeps its current value and no data input is sampled.
- Selection is a pure copy: no sign extension, truncation or arithmetic.
- All DATA_W bits pass unmodified, including all-ones values (e.g. 19'h7FFFF).
- Data inputs that are not selected have no effect on `in`.
- X or Z on sel is not legal stimulus. The implementation must resolve it as the hold case and must not propagate X into the register.

## Timing
- Reset value: `in` = 0 (all DATA_W bits).
  - Asserting rst clears `in` immediately, without waiting for a clock edge.
  - While rst is high, `in` stays 0 regardless of clock or inputs.
- Latency: 1 cycle. On each rising clk edge with rst low, `in` takes the value selected by sel and the data inputs sampled at that edge.
- Changing sel or the data inputs between edges has no visible effect until the next edge. `in` never glitches mid-cycle.
- Deassertion of rst: the first rising edge after rst falls loads the selected value normally. There is no extra recovery cycle.
- Reset asserted mid-operation (including during a run of hold cycles): `in` goes to 0 at once. Hold cycles after reset hold 0.
- Back-to-back select changes on consecutive edges each take effect. There is no dead cycle.
- Handshake: none. The block is always ready.

## Structure
- Shared CPU package holds:
  - the select constants FWD_EX = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10, FWD_HOLD = 2'b11;
  - the CPU data-width constant (19), so DATA_W defaults from it.
- Sub-module: `mux3_comb`, a purely combinational 3:1 selector (DATA_W wide, sel 2 bits). For 2'b11 it outputs a "no-select" flag, which the wrapper uses as its hold enable.
- alu_mux = mux3_comb + one DATA_W-bit output register with async reset and load enable.
- The forwarding unit that generates sel, and the ALU, are outside this block.

## Test plan
All scenarios use DATA_W = 19, EX_data = 19'h1A5A5, MEM_data = 19'h15A5A, WB_data = 19'h7FFFF unless stated otherwise.

1. Reset: assert rst with no clock edge -> `in` = 19'h00000 immediately. It stays 0 across edges while rst is high.
2. Routing: release rst, then apply sel = 00, 01, 10 on consecutive edges -> after each edge `in` = 19'h1A5A5, 19'h15A5A, 19'h7FFFF respectively, one cycle after sel is applied.
3. Hold: with `in` = 19'h15A5A, set sel = 11 and change all data inputs to 19'h00001 for 3 edges -> `in` stays 19'h15A5A.
4. Isolation and latency:
   - With sel = 00, change MEM_data and WB_data every cycle -> `in` tracks only EX_data.
   - Change EX_data mid-cycle -> `in` updates only at the next edge.
5. Async reset mid-run: with `in` = 19'h7FFFF, pulse rst between edges -> `in` = 0 before the next edge. The first edge after release with sel = 01 gives 19'h15A5A.
6. Width extremes: each source driven with 19'h00000 and then 19'h7FFFF -> `in` matches bit-exactly. No bits above bit 18 exist and none are dropped.
